ex_mem_skid_reg: RTL

//  - EX->MEM pipeline stage directly downstream of the 16-bit ALU.
//  - 2-entry skid buffer: captures ALU result/flags plus writeback and memory control.
//  - Valid/ready handshake decouples EX from MEM stalls without a combinational ready path.
//  - Exports the head entry as a forwarding source for the ALU operand muxes.

---
 rtl/ex_mem_skid_reg.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register: 2-entry skid buffer with registered in_ready and a forwarding tap on the head.
// Optional overflow trap enabled by defining OFL_TRAP_EN.
module ex_mem_skid_reg #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_ofl,
    input  logic              alu_cout,
    input  logic              alu_z,
    input  logic              ofl_chk,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic              wb_en,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [DATA_W-1:0] st_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] q_alu,
    output logic              q_ofl,
    output logic              q_cout,
    output logic              q_z,
    output logic [REG_W-1:0]  q_wb_reg,
    output logic              q_wb_en,
    output logic              q_mem_rd,
    output logic              q_mem_wr,
    output logic [DATA_W-1:0] q_st_data,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic              trap
);

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic              ofl;
        logic              cout;
        logic              z;
        logic [REG_W-1:0]  wb_reg;
        logic              wb_en;
        logic              mem_rd;
        logic              mem_wr;
        logic [DATA_W-1:0] st_data;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state, state_nxt;
    entry_t head, skid, in_entry;
    logic   in_ready_r;
    logic   push, pop;
    logic   load_head_in, load_head_skid, load_skid;

    assign push = in_valid & in_ready_r;
    assign pop  = out_valid & out_ready;

    always_comb begin
        in_entry = '{alu: alu_out, ofl: alu_ofl, cout: alu_cout, z: alu_z,
                     wb_reg: wb_reg, wb_en: wb_en, mem_rd: mem_rd,
                     mem_wr: mem_wr, st_data: st_data};
`ifdef OFL_TRAP_EN
        // A trapping op must not commit architectural state downstream.
        if (ofl_chk && alu_ofl) begin
            in_entry.wb_en  = 1'b0;
            in_entry.mem_wr = 1'b0;
        end
`endif
    end

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_nxt      = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            EMPTY: if (push) begin
                state_nxt    = ONE;
                load_head_in = 1'b1;
            end
            ONE: begin
                if (push && pop) begin
                    load_head_in = 1'b1;
                end else if (push) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: if (pop) begin
                state_nxt      = ONE;
                load_head_skid = 1'b1;
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush wins: a concurrent pop still completes for MEM, a concurrent push is lost.
        if (flush) begin
            state_nxt      = EMPTY;
            load_head_in   = 1'b0;
            load_head_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready_r <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_r <= (state_nxt != FULL);
        end
    end

    // NOTE: entry registers are reset because q_* must read zero immediately after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (load_head_in)        head <= in_entry;
            else if (load_head_skid) head <= skid;
            if (load_skid)           skid <= in_entry;
        end
    end

`ifdef OFL_TRAP_EN
    logic trap_r;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            trap_r <= 1'b0;
        else if (flush)                     trap_r <= 1'b0;
        else if (push && ofl_chk && alu_ofl) trap_r <= 1'b1;
    end
    assign trap = trap_r;
`else
    wire unused_ofl_chk = ofl_chk;
    assign trap = 1'b0;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = (state != EMPTY);

    assign q_alu     = head.alu;
    assign q_ofl     = head.ofl;
    assign q_cout    = head.cout;
    assign q_z       = head.z;
    assign q_wb_reg  = head.wb_reg;
    assign q_wb_en   = head.wb_en;
    assign q_mem_rd  = head.mem_rd;
    assign q_mem_wr  = head.mem_wr;
    assign q_st_data = head.st_data;

    // Loads are never forwarded; their data only exists after MEM.
    assign fwd_valid = out_valid & head.wb_en & ~head.mem_rd;
    assign fwd_reg   = head.wb_reg;
    assign fwd_data  = head.alu;

endmodule
